square_motion_ctrl: RTL and testbench

Frame-synchronised controller that positions and renders a solid square sprite on the 96x64 RGB565 OLED pixel stream. It tracks the scan via `pixel_index`, updates the square centre only at frame boundaries (no tearing), and runs an IDLE/RUN/PAUSE state machine driven by single-cycle button pulses. It sits between the button debouncers and the OLED colour mux, and replaces a fixed-position square source.

---
 rtl/square_motion_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_square_motion_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/square_motion_ctrl.sv
//==============================================================================
// Module   : square_motion_ctrl
// Purpose  : Frame-synchronised mover and renderer for a solid square sprite on
//            the 96x64 RGB565 OLED pixel stream. Optional macro: SQUARE_BOUNCE_EN
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module square_motion_ctrl #(
    parameter int          HALF      = 6,
    parameter int          STEP      = 1,
    parameter int          FRAME_DIV = 4,
    parameter logic [15:0] COLOR     = 16'hF800
) (
    input  logic        clk25,
    input  logic        reset_n,
    input  logic [12:0] pixel_index,
    input  logic        btn_c,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        btn_l,
    input  logic        btn_r,
    output logic [15:0] color,
    output logic [6:0]  cx,
    output logic [5:0]  cy,
    output logic [1:0]  state
);

    localparam int              c_CNT_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FRAME_DIV - 1);
    localparam logic signed [7:0] c_STEP  = 8'(STEP);
    localparam logic signed [7:0] c_HALF  = 8'(HALF);
    localparam logic signed [7:0] c_X_MAX = 8'(95 - HALF);
    localparam logic signed [7:0] c_Y_MAX = 8'(63 - HALF);
    localparam logic [12:0]       c_PIXELS = 13'd6144;

`ifdef SQUARE_BOUNCE_EN
    localparam bit c_BOUNCE = 1'b1;
`else
    localparam bit c_BOUNCE = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_R = 2'd0,
        DIR_L = 2'd1,
        DIR_U = 2'd2,
        DIR_D = 2'd3
    } dir_t;

    state_t               state_q, state_d;
    dir_t                 dir_q, dir_d;
    logic [c_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [12:0]          prev_idx_q, prev_idx_d;
    logic [6:0]           cx_q, cx_d;
    logic [5:0]           cy_q, cy_d;
    logic [15:0]          color_q, color_d;

    logic                 w_frame_start;
    logic                 w_move;
    logic                 w_clamp;
    logic signed [7:0]    w_nx;
    logic signed [7:0]    w_ny;
    logic [6:0]           w_x;
    logic [6:0]           w_y;
    logic signed [7:0]    w_dx;
    logic signed [7:0]    w_dy;

    assign w_frame_start = (pixel_index == 13'd0) && (prev_idx_q != 13'd0);
    assign w_x = 7'(pixel_index % 13'd96);
    assign w_y = 7'(pixel_index / 13'd96);

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        frame_cnt_d = frame_cnt_q;
        prev_idx_d  = pixel_index;
        cx_d        = cx_q;
        cy_d        = cy_q;
        w_move      = 1'b0;
        w_clamp     = 1'b0;
        w_nx        = signed'({1'b0, cx_q});
        w_ny        = signed'({2'b00, cy_q});
        w_dx        = 8'sd0;
        w_dy        = 8'sd0;
        color_d     = 16'h0000;

        // Counting follows the state held before this cycle's button press.
        case (state_q)
            ST_RUN: begin
                if (w_frame_start) begin
                    if (frame_cnt_q == c_CNT_LAST) begin
                        w_move      = 1'b1;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + c_CNT_W'(1);
                    end
                end
            end
            ST_IDLE: frame_cnt_d = '0;
            default: ;
        endcase

        if (w_move) begin
            case (dir_q)
                DIR_R:   w_nx = w_nx + c_STEP;
                DIR_L:   w_nx = w_nx - c_STEP;
                DIR_U:   w_ny = w_ny - c_STEP;
                default: w_ny = w_ny + c_STEP;
            endcase
            if (w_nx < c_HALF) begin
                w_nx    = c_HALF;
                w_clamp = 1'b1;
            end else if (w_nx > c_X_MAX) begin
                w_nx    = c_X_MAX;
                w_clamp = 1'b1;
            end
            if (w_ny < c_HALF) begin
                w_ny    = c_HALF;
                w_clamp = 1'b1;
            end else if (w_ny > c_Y_MAX) begin
                w_ny    = c_Y_MAX;
                w_clamp = 1'b1;
            end
            cx_d = w_nx[6:0];
            cy_d = w_ny[5:0];
            if (w_clamp && c_BOUNCE) begin
                case (dir_q)
                    DIR_R:   dir_d = DIR_L;
                    DIR_L:   dir_d = DIR_R;
                    DIR_U:   dir_d = DIR_D;
                    default: dir_d = DIR_U;
                endcase
            end
        end

        // A fresh direction command takes precedence over an automatic reversal.
        if (btn_u) begin
            dir_d = DIR_U;
        end else if (btn_d) begin
            dir_d = DIR_D;
        end else if (btn_l) begin
            dir_d = DIR_L;
        end else if (btn_r) begin
            dir_d = DIR_R;
        end

        if (btn_c) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end

        w_dx = signed'({1'b0, w_x}) - signed'({1'b0, cx_q});
        w_dy = signed'({1'b0, w_y}) - signed'({2'b00, cy_q});
        if (w_dx < 8'sd0) begin
            w_dx = -w_dx;
        end
        if (w_dy < 8'sd0) begin
            w_dy = -w_dy;
        end
        if ((pixel_index < c_PIXELS) && (w_dx <= c_HALF) && (w_dy <= c_HALF)) begin
            color_d = COLOR;
        end
    end

    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_R;
            frame_cnt_q <= '0;
            prev_idx_q  <= 13'd0;
            cx_q        <= 7'd48;
            cy_q        <= 6'd32;
            color_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            frame_cnt_q <= frame_cnt_d;
            prev_idx_q  <= prev_idx_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            color_q     <= color_d;
        end
    end

    assign color = color_q;
    assign cx    = cx_q;
    assign cy    = cy_q;
    assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_square_motion_ctrl.sv
//==============================================================================
// Module   : tb_square_motion_ctrl
// Purpose  : Scoreboard bench for square_motion_ctrl with a behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_square_motion_ctrl;

    localparam int          HALF      = 6;
    localparam int          STEP      = 1;
    localparam int          FRAME_DIV = 4;
    localparam logic [15:0] COLOR     = 16'hF800;

    logic        clk25 = 1'b0;
    logic        reset_n = 1'b0;
    logic [12:0] pixel_index = 13'd0;
    logic        btn_c = 1'b0;
    logic        btn_u = 1'b0;
    logic        btn_d = 1'b0;
    logic        btn_l = 1'b0;
    logic        btn_r = 1'b0;
    logic [15:0] color;
    logic [6:0]  cx;
    logic [5:0]  cy;
    logic [1:0]  state;

    always #5 clk25 = ~clk25;

    square_motion_ctrl #(
        .HALF      (HALF),
        .STEP      (STEP),
        .FRAME_DIV (FRAME_DIV),
        .COLOR     (COLOR)
    ) dut (
        .clk25       (clk25),
        .reset_n     (reset_n),
        .pixel_index (pixel_index),
        .btn_c       (btn_c),
        .btn_u       (btn_u),
        .btn_d       (btn_d),
        .btn_l       (btn_l),
        .btn_r       (btn_r),
        .color       (color),
        .cx          (cx),
        .cy          (cy),
        .state       (state)
    );

    typedef struct {
        int color;
        int cx;
        int cy;
        int st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Behavioural model: state 0 idle, 1 run, 2 pause; dir words kept as strings.
    int    m_state = 0;
    string m_dir = "RIGHT";
    int    m_cnt = 0;
    int    m_cx = 48;
    int    m_cy = 32;
    int    m_prev = 0;

    function automatic int ref_color(int idx, int sx, int sy);
        int dx, dy;
        if (idx >= 6144) return 0;
        dx = (idx % 96) - sx;
        dy = (idx / 96) - sy;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return (dx <= HALF && dy <= HALF) ? int'(COLOR) : 0;
    endfunction

    function automatic string opposite(string d);
        if (d == "RIGHT") return "LEFT";
        if (d == "LEFT")  return "RIGHT";
        if (d == "UP")    return "DOWN";
        return "UP";
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk25);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("color", int'(color), e.color);
                check("cx",    int'(cx),    e.cx);
                check("cy",    int'(cy),    e.cy);
                check("state", int'(state), e.st);
            end
        end
    end

    task automatic step(input bit rn, input int idx, input bit c, input bit u,
                        input bit d, input bit l, input bit r);
        exp_t  e;
        bit    fs, move, clamp;
        int    nx, ny;
        string ndir;
        @(negedge clk25);
        reset_n     = rn;
        pixel_index = 13'(idx);
        btn_c = c; btn_u = u; btn_d = d; btn_l = l; btn_r = r;

        e.color = rn ? ref_color(idx, m_cx, m_cy) : 0;
        if (!rn) begin
            m_state = 0; m_dir = "RIGHT"; m_cnt = 0;
            m_cx = 48; m_cy = 32; m_prev = 0;
        end else begin
            fs = (idx == 0) && (m_prev != 0);
            move = 1'b0;
            if (m_state == 1 && fs) begin
                m_cnt++;
                if (m_cnt == FRAME_DIV) begin
                    m_cnt = 0;
                    move = 1'b1;
                end
            end
            ndir = m_dir;
            if (move) begin
                nx = m_cx; ny = m_cy; clamp = 1'b0;
                if (m_dir == "RIGHT") nx = nx + STEP;
                else if (m_dir == "LEFT") nx = nx - STEP;
                else if (m_dir == "UP") ny = ny - STEP;
                else ny = ny + STEP;
                if (nx < HALF)      begin nx = HALF;      clamp = 1'b1; end
                if (nx > 95 - HALF) begin nx = 95 - HALF; clamp = 1'b1; end
                if (ny < HALF)      begin ny = HALF;      clamp = 1'b1; end
                if (ny > 63 - HALF) begin ny = 63 - HALF; clamp = 1'b1; end
`ifdef SQUARE_BOUNCE_EN
                if (clamp) ndir = opposite(m_dir);
`endif
                m_cx = nx; m_cy = ny;
            end
            if (u) ndir = "UP";
            else if (d) ndir = "DOWN";
            else if (l) ndir = "LEFT";
            else if (r) ndir = "RIGHT";
            m_dir = ndir;
            if (c) m_state = (m_state == 1) ? 2 : 1;
            m_prev = idx;
        end
        e.cx = m_cx; e.cy = m_cy; e.st = m_state;
        exp_q.push_back(e);
    endtask

    function automatic int pick_index();
        int x, y;
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(1, 8191));
        x = m_cx + int'($urandom_range(0, 18)) - 9;
        y = m_cy + int'($urandom_range(0, 18)) - 9;
        if (x < 0) x = 0;
        if (x > 95) x = 95;
        if (y < 0) y = 0;
        if (y > 63) y = 63;
        if (x == 0 && y == 0) x = 1;
        return y * 96 + x;
    endfunction

    task automatic frames(input int n);
        for (int f = 0; f < n; f++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            for (int k = 0; k < 12; k++) step(1, pick_index(), 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        int idx, wait_cnt;
        bit rn, c, u, d, l, r;

        for (int i = 0; i < 3; i++) step(0, int'($urandom_range(0, 8191)), 0, 0, 0, 0, 0);

        // One full scan, including the off-screen index range.
        for (int i = 0; i < 6152; i++) step(1, i, 0, 0, 0, 0, 0);

        step(1, 100, 1, 0, 0, 0, 0);
        frames(8);
        frames(170);

        frames(2);
        step(1, 5, 1, 0, 0, 0, 0);
        frames(10);
        step(1, 5, 1, 0, 0, 0, 0);
        frames(4);

        step(1, 7, 0, 0, 0, 1, 0);
        frames(20);
        step(1, 9, 0, 1, 0, 1, 0);
        frames(8);

        for (int k = 0; k < 5; k++) step(1, 2990 + k, 0, 0, 0, 0, 0);
        step(0, 3000, 0, 0, 0, 0, 0);
        step(1, 3001, 0, 0, 0, 0, 0);
        frames(3);
        step(1, 11, 1, 0, 1, 0, 0);
        frames(120);
        step(1, 13, 0, 1, 0, 0, 0);
        frames(120);

        for (int i = 0; i < 4000; i++) begin
            idx = ($urandom_range(0, 14) == 0) ? 0 : pick_index();
            rn  = ($urandom_range(0, 799) != 0);
            c   = ($urandom_range(0, 59) == 0);
            u   = (idx != 0) && ($urandom_range(0, 79) == 0);
            d   = (idx != 0) && ($urandom_range(0, 79) == 0);
            l   = (idx != 0) && ($urandom_range(0, 79) == 0);
            r   = (idx != 0) && ($urandom_range(0, 79) == 0);
            step(rn, idx, c, u, d, l, r);
        end

        @(negedge clk25);
        btn_c = 0; btn_u = 0; btn_d = 0; btn_l = 0; btn_r = 0;
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk25);
            wait_cnt++;
        end
        if (exp_q.size() > 0) check("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
